// File: rtl/alu_control_pipe.sv
// Pipelined LEGv8 ALU control: decodes {ALUOp, opcode} into a registered ALUCtl
// behind a valid/ready handshake, stalling input while MUL/SDIV iterate.
module alu_control_pipe #(
  parameter int OPCODE_W   = 11,
  parameter int CTL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          ALUOp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTL_W-1:0]    ALUCtl,
  output logic                multi_cycle,
  output logic                illegal,
  output logic [CNT_W-1:0]    busy_cnt
);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(11'b10001011000);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(11'b11001011000);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(11'b10001010000);
  localparam logic [OPCODE_W-1:0] OP_ORR  = OPCODE_W'(11'b10101010000);
  localparam logic [OPCODE_W-1:0] OP_EOR  = OPCODE_W'(11'b11001010000);
  localparam logic [OPCODE_W-1:0] OP_LSL  = OPCODE_W'(11'b11010011011);
  localparam logic [OPCODE_W-1:0] OP_LSR  = OPCODE_W'(11'b11010011010);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(11'b10011011000);
  localparam logic [OPCODE_W-1:0] OP_SDIV = OPCODE_W'(11'b10011010110);

  // Immediate formats carry one fewer opcode bit, so they match on opcode[MSB:1].
  localparam logic [OPCODE_W-2:0] OP_ADDI = (OPCODE_W-1)'(10'b1001000100);
  localparam logic [OPCODE_W-2:0] OP_SUBI = (OPCODE_W-1)'(10'b1101000100);
  localparam logic [OPCODE_W-2:0] OP_ANDI = (OPCODE_W-1)'(10'b1001001000);
  localparam logic [OPCODE_W-2:0] OP_ORRI = (OPCODE_W-1)'(10'b1011001000);

  localparam logic [CTL_W-1:0] CTL_AND  = CTL_W'(4'b0000);
  localparam logic [CTL_W-1:0] CTL_ORR  = CTL_W'(4'b0001);
  localparam logic [CTL_W-1:0] CTL_ADD  = CTL_W'(4'b0010);
  localparam logic [CTL_W-1:0] CTL_EOR  = CTL_W'(4'b0011);
  localparam logic [CTL_W-1:0] CTL_SUB  = CTL_W'(4'b0110);
  localparam logic [CTL_W-1:0] CTL_PASS = CTL_W'(4'b0111);
  localparam logic [CTL_W-1:0] CTL_LSL  = CTL_W'(4'b1000);
  localparam logic [CTL_W-1:0] CTL_LSR  = CTL_W'(4'b1001);
  localparam logic [CTL_W-1:0] CTL_MUL  = CTL_W'(4'b1010);
  localparam logic [CTL_W-1:0] CTL_DIV  = CTL_W'(4'b1011);
  localparam logic [CTL_W-1:0] CTL_BAD  = CTL_W'(4'b1111);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state;
  logic [CTL_W-1:0] dec_ctl;
  logic             dec_illegal;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_cnt;
  logic             accept;

  // The opcode is only examined under ALUOp 10/11 so an undriven opcode on
  // loads/stores/branches cannot leak into the registered outputs.
  always_comb begin
    dec_ctl     = CTL_BAD;
    dec_illegal = 1'b1;
    dec_multi   = 1'b0;
    dec_cnt     = '0;
    case (ALUOp)
      2'b00: begin
        dec_ctl     = CTL_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_ctl     = CTL_PASS;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        dec_illegal = 1'b0;
        case (opcode)
          OP_ADD:  dec_ctl = CTL_ADD;
          OP_SUB:  dec_ctl = CTL_SUB;
          OP_AND:  dec_ctl = CTL_AND;
          OP_ORR:  dec_ctl = CTL_ORR;
          OP_EOR:  dec_ctl = CTL_EOR;
          OP_LSL:  dec_ctl = CTL_LSL;
          OP_LSR:  dec_ctl = CTL_LSR;
          OP_MUL: begin
            dec_ctl   = CTL_MUL;
            dec_multi = 1'b1;
            dec_cnt   = CNT_W'(MUL_CYCLES - 1);
          end
          OP_SDIV: begin
            dec_ctl   = CTL_DIV;
            dec_multi = 1'b1;
            dec_cnt   = CNT_W'(DIV_CYCLES - 1);
          end
          default: begin
            dec_ctl     = CTL_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_illegal = 1'b0;
        case (opcode[OPCODE_W-1:1])
          OP_ADDI: dec_ctl = CTL_ADD;
          OP_SUBI: dec_ctl = CTL_SUB;
          OP_ANDI: dec_ctl = CTL_AND;
          OP_ORRI: dec_ctl = CTL_ORR;
          default: begin
            dec_ctl     = CTL_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign in_ready = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // A decode whose countdown is zero goes straight to HOLD; otherwise BUSY
  // counts down to zero and spends one more edge before presenting the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      ALUCtl      <= '0;
      multi_cycle <= 1'b0;
      illegal     <= 1'b0;
      busy_cnt    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy_cnt  <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            ALUCtl      <= dec_ctl;
            multi_cycle <= dec_multi;
            illegal     <= dec_illegal;
            if (dec_cnt == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              busy_cnt  <= '0;
            end else begin
              state     <= BUSY;
              out_valid <= 1'b0;
              busy_cnt  <= dec_cnt;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (busy_cnt == '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Randomised self-checking bench for alu_control_pipe against a transaction-level
// model that tracks each op by its latency and the edges elapsed since accept.
module tb_alu_control_pipe;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 16;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      opcode;
  logic [1:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       ALUCtl;
  logic             multi_cycle;
  logic             illegal;
  logic [CNT_W-1:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  // Model: an op in flight has latency n; elapsed counts edges after its accept.
  bit       m_has;
  int       m_n;
  int       m_elapsed;
  logic [3:0] m_ctl;
  bit       m_multi;
  bit       m_ill;

  logic [10:0] op_table [13];

  alu_control_pipe #(
    .OPCODE_W(11), .CTL_W(4), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .ALUCtl(ALUCtl), .multi_cycle(multi_cycle), .illegal(illegal), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [10:0] opc,
                                     output logic [3:0] ctl, output bit ill,
                                     output bit mul, output int n);
    ctl = 4'b1111; ill = 1'b1; mul = 1'b0; n = 1;
    if (op == 2'b00) begin
      ctl = 4'b0010; ill = 1'b0;
    end else if (op == 2'b01) begin
      ctl = 4'b0111; ill = 1'b0;
    end else if (op == 2'b10) begin
      ill = 1'b0;
      case (opc)
        11'b10001011000: ctl = 4'b0010;
        11'b11001011000: ctl = 4'b0110;
        11'b10001010000: ctl = 4'b0000;
        11'b10101010000: ctl = 4'b0001;
        11'b11001010000: ctl = 4'b0011;
        11'b11010011011: ctl = 4'b1000;
        11'b11010011010: ctl = 4'b1001;
        11'b10011011000: begin ctl = 4'b1010; mul = 1'b1; n = MUL_CYCLES; end
        11'b10011010110: begin ctl = 4'b1011; mul = 1'b1; n = DIV_CYCLES; end
        default:         ill = 1'b1;
      endcase
    end else begin
      ill = 1'b0;
      case (opc[10:1])
        10'b1001000100: ctl = 4'b0010;
        10'b1101000100: ctl = 4'b0110;
        10'b1001001000: ctl = 4'b0000;
        10'b1011001000: ctl = 4'b0001;
        default:        ill = 1'b1;
      endcase
    end
  endfunction

  function automatic bit model_valid();
    return m_has && (m_elapsed >= ((m_n == 1) ? 0 : m_n));
  endfunction

  function automatic int model_busy();
    return (m_has && m_n > 1 && m_elapsed < m_n) ? (m_n - 1 - m_elapsed) : 0;
  endfunction

  function automatic bit model_in_ready();
    return !flush && (!m_has || (model_valid() && out_ready));
  endfunction

  task automatic model_update();
    logic [3:0] ctl;
    bit ill, mul;
    int n;
    bit acc;
    acc = in_valid && model_in_ready();
    if (rst) begin
      m_has = 0; m_ctl = 4'b0000; m_multi = 0; m_ill = 0;
    end else if (flush) begin
      m_has = 0;
    end else if (acc) begin
      ref_decode(ALUOp, opcode, ctl, ill, mul, n);
      m_has = 1; m_n = n; m_elapsed = 0; m_ctl = ctl; m_multi = mul; m_ill = ill;
    end else if (model_valid() && out_ready) begin
      m_has = 0;
    end else if (m_has && m_elapsed < 1000) begin
      m_elapsed++;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [10:0] opc,
                               input bit ordy, input bit fl, input bit rs);
    in_valid = v; ALUOp = op; opcode = opc; out_ready = ordy; flush = fl; rst = rs;
  endtask

  // One cycle: compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit ev;
    @(negedge clk);
    ev = model_valid();
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, ev});
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, model_in_ready()});
    checkOutput("busy_cnt", 32'(busy_cnt), 32'(model_busy()));
    if (ev) begin
      checkOutput("ALUCtl", {28'b0, ALUCtl}, {28'b0, m_ctl});
      checkOutput("multi_cycle", {31'b0, multi_cycle}, {31'b0, m_multi});
      checkOutput("illegal", {31'b0, illegal}, {31'b0, m_ill});
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [10:0] opc;
    logic [10:0] xop;
    op_table = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                 11'b11001010000, 11'b11010011011, 11'b11010011010, 11'b10011011000,
                 11'b10011010110, 11'b10010001000, 11'b11010001000, 11'b10010010000,
                 11'b10110010000};
    xop = 'x;
    m_has = 0; m_n = 1; m_elapsed = 0; m_ctl = 4'b0000; m_multi = 0; m_ill = 0;
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 1);

    // Reset for two cycles, then idle with in_ready high.
    step(); step();
    checkOutput("rst_ALUCtl", {28'b0, ALUCtl}, 32'h0);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'h0);
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0);
    step();

    // Load/store and branch decode with an undriven opcode.
    applyStimulus(1, 2'b00, xop, 1, 0, 0); step();
    applyStimulus(1, 2'b01, xop, 1, 0, 0); step();
    applyStimulus(0, 2'b00, xop, 1, 0, 0); step(); step();

    // R-format ADD/SUB/AND/ORR/EOR streamed back to back.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'b10, op_table[i], 1, 0, 0); step();
    end
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step();

    // MUL: countdown 3,2,1,0 then result.
    applyStimulus(1, 2'b10, op_table[7], 1, 0, 0); step();
    checkOutput("mul_busy_start", 32'(busy_cnt), 32'd3);
    applyStimulus(1, 2'b10, op_table[0], 1, 0, 0);
    for (int i = 0; i < 4; i++) step();
    checkOutput("mul_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("mul_ctl", {28'b0, ALUCtl}, 32'hA);
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step(); step();

    // ADD held under backpressure, then an illegal immediate-format opcode.
    applyStimulus(1, 2'b10, op_table[0], 1, 0, 0); step();
    applyStimulus(1, 2'b10, op_table[1], 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    applyStimulus(1, 2'b11, 11'b11111111111, 1, 0, 0); step();
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step();
    checkOutput("illegal_ctl", {28'b0, ALUCtl}, 32'hF);
    checkOutput("illegal_flag", {31'b0, illegal}, 32'd1);
    step();

    // SDIV flushed when the countdown reaches 7.
    applyStimulus(1, 2'b10, op_table[8], 1, 0, 0); step();
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0);
    for (int i = 0; i < 20 && busy_cnt != 7; i++) step();
    checkOutput("div_reach7", 32'(busy_cnt), 32'd7);
    applyStimulus(1, 2'b10, op_table[0], 1, 1, 0); step();
    checkOutput("flush_busy", 32'(busy_cnt), 32'd0);
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step();

    // SDIV aborted by reset.
    applyStimulus(1, 2'b10, op_table[8], 1, 0, 0); step();
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step(); step();
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 1); step();
    checkOutput("rst_div_ctl", {28'b0, ALUCtl}, 32'h0);
    checkOutput("rst_div_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_div_multi", {31'b0, multi_cycle}, 32'd0);
    applyStimulus(0, 2'b00, 11'd0, 1, 0, 0); step();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        opc = op_table[$urandom_range(0, 12)];
        if ($urandom_range(0, 1) == 1) opc[0] = ~opc[0];
      end else begin
        opc = 11'($urandom);
      end
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), opc,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 199) < 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
